// File: rtl/reg_read_arbiter.sv
// reg_read_arbiter: round-robin sharing of the registered 32-entry register-file read mux.
//
// Ports:
//   Clock      rising-edge clock, shared with the register-file mux
//   Reset_n    synchronous active-low reset
//   Req        per-requester read request (level)
//   ReqAddr    requester i address in bits [i*AW +: AW]
//   Ack        registered one-hot grant acknowledge (one-cycle pulse)
//   ReadAdd    registered address driven to the mux select
//   MuxData    registered output of the register-file mux
//   RespValid  response valid (one-cycle pulse)
//   RespId     requester index of the response
//   RespData   register contents for the response
//   Busy       a read is in flight in either tracking stage
module reg_read_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic [NREQ-1:0]      Req,
    input  logic [NREQ*AW-1:0]   ReqAddr,
    output logic [NREQ-1:0]      Ack,
    output logic [AW-1:0]        ReadAdd,
    input  logic [DW-1:0]        MuxData,
    output logic                 RespValid,
    output logic [2:0]           RespId,
    output logic [DW-1:0]        RespData,
    output logic                 Busy
);

    logic [2:0]    last;
    logic [2:0]    grant;
    logic          hit;
    logic [7:0]    elig;
    logic [3:0]    sum;
    logic [AW-1:0] addr [8];
    logic          s1_valid, s2_valid;
    logic [2:0]    s1_id, s2_id;

    // Requesters still seeing their Ack are masked so a held Req cannot win twice in a row.
    // Scanning from the far end lets the nearest eligible requester after last overwrite the rest.
    always_comb begin
        elig  = 8'(Req & ~Ack);
        hit   = 1'b0;
        grant = last;
        sum   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            sum = {1'b0, last} + 4'(k);
            sum = (sum >= 4'(NREQ)) ? sum - 4'(NREQ) : sum;
            if (elig[sum[2:0]]) begin
                hit   = 1'b1;
                grant = sum[2:0];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++)
            addr[i] = '0;
        for (int i = 0; i < NREQ; i++)
            addr[i] = ReqAddr[i*AW +: AW];
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            Ack       <= '0;
            ReadAdd   <= '0;
            last      <= 3'(NREQ - 1);
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            s2_valid  <= 1'b0;
            s2_id     <= '0;
            RespValid <= 1'b0;
            RespId    <= '0;
            RespData  <= '0;
        end else begin
            Ack      <= hit ? NREQ'(8'd1 << grant) : '0;
            s1_valid <= hit;
            s1_id    <= grant;
            if (hit) begin
                ReadAdd <= addr[grant];
                last    <= grant;
            end
            // The mux registers R[ReadAdd] on the same edge stage1 advances to stage2.
            s2_valid  <= s1_valid;
            s2_id     <= s1_id;
            RespValid <= s2_valid;
            if (s2_valid) begin
                RespId   <= s2_id;
                RespData <= MuxData;
            end
        end
    end

    assign Busy = s1_valid | s2_valid;

endmodule

// File: tb/tb_reg_read_arbiter.sv
// tb_reg_read_arbiter: directed plan plus randomized traffic against a transaction-level model.
module tb_reg_read_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic              Clock;
    logic              Reset_n;
    logic [NREQ-1:0]   Req;
    logic [NREQ*AW-1:0] ReqAddr;
    logic [NREQ-1:0]   Ack;
    logic [AW-1:0]     ReadAdd;
    logic [DW-1:0]     MuxData;
    logic              RespValid;
    logic [2:0]        RespId;
    logic [DW-1:0]     RespData;
    logic              Busy;

    reg_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Req(Req), .ReqAddr(ReqAddr),
        .Ack(Ack), .ReadAdd(ReadAdd), .MuxData(MuxData), .RespValid(RespValid),
        .RespId(RespId), .RespData(RespData), .Busy(Busy)
    );

    logic [DW-1:0] rf [32];

    always @(posedge Clock) MuxData <= rf[ReadAdd];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } resp_t;

    resp_t          q[$];
    int             checks = 0;
    int             failures = 0;
    int             edge_n = 0;
    int             m_last = NREQ - 1;
    logic [NREQ-1:0] m_ack = '0;
    logic [AW-1:0]  m_radd = '0;
    logic           m_rv = 1'b0;
    logic [2:0]     m_rid = '0;
    logic [DW-1:0]  m_rdata = '0;
    logic           g_now = 1'b0, g_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int g;
        logic [AW-1:0] a;
        g = -1;
        a = '0;
        if (Reset_n)
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (m_last + k) % NREQ;
                if (g < 0 && Req[i] && !m_ack[i]) g = i;
            end
        if (g >= 0) a = ReqAddr[g*AW +: AW];
        @(posedge Clock);
        #1;
        edge_n++;
        if (!Reset_n) begin
            q.delete();
            m_ack = '0; m_last = NREQ - 1; m_radd = '0;
            m_rv = 1'b0; m_rid = '0; m_rdata = '0;
            g_now = 1'b0; g_prev = 1'b0;
        end else begin
            m_ack = '0;
            g_prev = g_now;
            g_now = (g >= 0);
            if (g >= 0) begin
                m_ack[g] = 1'b1;
                m_last = g;
                m_radd = a;
                q.push_back('{due: edge_n + 2, id: g, data: rf[a]});
            end
            if (q.size() > 0 && q[0].due == edge_n) begin
                m_rv = 1'b1;
                m_rid = 3'(q[0].id);
                m_rdata = q[0].data;
                void'(q.pop_front());
            end else
                m_rv = 1'b0;
        end
        chk("ack", 32'(Ack), 32'(m_ack));
        chk("read_add", 32'(ReadAdd), 32'(m_radd));
        chk("resp_valid", 32'(RespValid), 32'(m_rv));
        chk("resp_id", 32'(RespId), 32'(m_rid));
        chk("resp_data", RespData, m_rdata);
        chk("busy", 32'(Busy), 32'(g_now | g_prev));
    endtask

    task automatic do_reset();
        Req = '0;
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic drop_acked();
        for (int i = 0; i < NREQ; i++)
            if (m_ack[i]) Req[i] = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] ra;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        for (int n = 1; n <= 4; n++) rf[n] = 32'(n * 32'h11);
        rf[5]  = 32'hDEADBEEF;
        rf[31] = 32'hFFFFFFFF;
        Req = '0;
        ReqAddr = '0;
        Reset_n = 1'b0;
        tick();
        do_reset();
        chk("rst_ack", 32'(Ack), 0);
        chk("rst_read_add", 32'(ReadAdd), 0);
        chk("rst_resp_valid", 32'(RespValid), 0);
        chk("rst_resp_data", RespData, 0);
        chk("rst_busy", 32'(Busy), 0);

        // single read of R5
        Req = 4'b0001;
        ReqAddr[0 +: AW] = 5'd5;
        tick();
        chk("t1_ack", 32'(Ack), 1);
        chk("t1_busy0", 32'(Busy), 1);
        Req = '0;
        tick();
        chk("t1_busy1", 32'(Busy), 1);
        chk("t1_early", 32'(RespValid), 0);
        tick();
        chk("t1_valid", 32'(RespValid), 1);
        chk("t1_id", 32'(RespId), 0);
        chk("t1_data", RespData, 32'hDEADBEEF);
        chk("t1_busy2", 32'(Busy), 0);
        tick();
        chk("t1_pulse", 32'(RespValid), 0);
        chk("t1_hold", RespData, 32'hDEADBEEF);

        // all four requesters at once
        do_reset();
        Req = 4'b1111;
        for (int i = 0; i < NREQ; i++) ReqAddr[i*AW +: AW] = 5'(i + 1);
        for (int t = 0; t < 6; t++) begin
            tick();
            if (t < 4) chk("t2_ack", 32'(Ack), 32'(1 << t));
            if (t >= 2) begin
                chk("t2_valid", 32'(RespValid), 1);
                chk("t2_data", RespData, 32'((t - 1) * 32'h11));
            end
            drop_acked();
        end

        // two requesters holding Req alternate
        do_reset();
        Req = 4'b0101;
        ReqAddr = 20'($urandom);
        for (int t = 0; t < 6; t++) begin
            tick();
            chk("t3_ack", 32'(Ack), (t % 2) ? 4 : 1);
            for (int i = 0; i < NREQ; i++)
                if (m_ack[i]) ReqAddr[i*AW +: AW] = 5'($urandom);
        end
        Req = '0;
        repeat (3) tick();

        // pointer wrap from requester 3
        do_reset();
        Req = 4'b1000;
        tick();
        chk("t4_ack3", 32'(Ack), 8);
        Req = '0;
        tick();
        Req = 4'b1001;
        tick();
        chk("t4_wrap", 32'(Ack), 1);
        Req[0] = 1'b0;
        tick();
        chk("t4_then3", 32'(Ack), 8);
        Req = '0;
        repeat (3) tick();

        // boundary addresses
        Req = 4'b0011;
        ReqAddr[0 +: AW] = 5'd0;
        ReqAddr[AW +: AW] = 5'd31;
        tick();
        chk("t5_add0", 32'(ReadAdd), 0);
        Req[0] = 1'b0;
        tick();
        chk("t5_add31", 32'(ReadAdd), 31);
        Req = '0;
        tick();
        chk("t5_data0", RespData, rf[0]);
        tick();
        chk("t5_data31", RespData, 32'hFFFFFFFF);
        repeat (2) tick();

        // reset with two reads in flight
        Req = 4'b0011;
        ReqAddr = 20'($urandom);
        tick();
        drop_acked();
        tick();
        drop_acked();
        chk("t6_busy_pre", 32'(Busy), 1);
        Req = '0;
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        chk("t6_ack", 32'(Ack), 0);
        chk("t6_read_add", 32'(ReadAdd), 0);
        chk("t6_valid", 32'(RespValid), 0);
        chk("t6_id", 32'(RespId), 0);
        chk("t6_data", RespData, 0);
        chk("t6_busy", 32'(Busy), 0);
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("t6_no_resp", 32'(RespValid), 0);
        end
        ra = 5'($urandom);
        Req = 4'b0100;
        ReqAddr[2*AW +: AW] = ra;
        tick();
        chk("t6_ack2", 32'(Ack), 4);
        Req = '0;
        tick();
        tick();
        chk("t6_valid_after", 32'(RespValid), 1);
        chk("t6_id_after", 32'(RespId), 2);
        chk("t6_data_after", RespData, rf[ra]);

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!Req[i]) begin
                    if ($urandom_range(1) == 1) begin
                        Req[i] = 1'b1;
                        ReqAddr[i*AW +: AW] = 5'($urandom);
                    end
                end else if (m_ack[i]) begin
                    if ($urandom_range(1) == 1) Req[i] = 1'b0;
                    else ReqAddr[i*AW +: AW] = 5'($urandom);
                end else if ($urandom_range(7) == 0)
                    Req[i] = 1'b0;
            end
            Reset_n = ($urandom_range(199) != 0);
            tick();
            Reset_n = 1'b1;
            if (!Reset_n) Req = '0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
